// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and bus widths.
package apb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

  localparam int APB_ADDR_W = 33;
  localparam int APB_DATA_W = 32;

endpackage

// File: rtl/apb_slave_regfile.sv
// Word array for the APB completer: synchronous write, combinational read.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_wr_idx,
  input  logic [APB_DATA_W-1:0] i_wr_data,
  input  logic [AW-1:0]         i_rd_idx,
  output logic [APB_DATA_W-1:0] o_rd_data
);

  // Contents are deliberately not reset.
  logic [APB_DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer with a word-addressed register array, optional wait states
// (macro APB_SLV_WAIT_EN) and pslverr on out-of-range or misaligned accesses.
//
//  state     | meaning
//  ----------+---------------------------------------------------------
//  ST_IDLE   | waiting for SETUP (psel=1, penable=0)
//  ST_ACCESS | transfer captured; counting wait states, pready at zero
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [APB_ADDR_W-1:0] paddr,
  input  logic [APB_DATA_W-1:0] pwdata,
  output logic [APB_DATA_W-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH * 4);

  apb_state_e            r_state;
  apb_state_e            w_state_nxt;
  logic                  r_write;
  logic                  r_err;
  logic [AW-1:0]         r_idx;
  logic [APB_DATA_W-1:0] r_wdata;
  logic [APB_DATA_W-1:0] r_prdata;

  logic                  w_setup;
  logic                  w_addr_err;
  logic                  w_cnt_zero;
  logic                  w_mem_we;
  logic [APB_DATA_W-1:0] w_rd_data;
  logic                  w_unused_addr_msb;

  // Bit 32 belongs to the master's decode and is not part of our address.
  assign w_unused_addr_msb = paddr[APB_ADDR_W-1];

  assign w_setup    = (r_state == ST_IDLE) && psel && !penable;
  assign w_addr_err = (paddr[31:0] >= BYTE_LIMIT) || (paddr[1:0] != 2'b00);

`ifdef APB_SLV_WAIT_EN
  localparam int CW = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);
  logic [CW-1:0] r_cnt;

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_cnt <= '0;
    end else if (w_setup) begin
      r_cnt <= CW'(WAIT_STATES);
    end else if (r_state == ST_ACCESS) begin
      if (!psel) begin
        r_cnt <= '0;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign w_cnt_zero = (r_cnt == '0);
`else
  logic w_unused_wait_cfg;
  assign w_unused_wait_cfg = (WAIT_STATES != 0);
  assign w_cnt_zero        = 1'b1;
`endif

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_setup) begin
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!psel || w_cnt_zero) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Transfer attributes are frozen at SETUP; the bus is not re-sampled later.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_write  <= 1'b0;
      r_err    <= 1'b0;
      r_idx    <= '0;
      r_wdata  <= '0;
      r_prdata <= '0;
    end else if (w_setup) begin
      r_write <= pwrite;
      r_err   <= w_addr_err;
      r_idx   <= paddr[AW+1:2];
      r_wdata <= pwdata;
      if (w_addr_err) begin
        r_prdata <= '0;
      end else if (!pwrite) begin
        r_prdata <= w_rd_data;
      end
    end
  end

  assign pready   = (r_state == ST_ACCESS) && w_cnt_zero;
  assign pslverr  = pready && r_err;
  assign prdata   = r_prdata;
  assign w_mem_we = pready && psel && r_write && !r_err;

  apb_slave_regfile #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_regfile (
    .i_clk     (pclk),
    .i_we      (w_mem_we),
    .i_wr_idx  (r_idx),
    .i_wr_data (r_wdata),
    .i_rd_idx  (paddr[AW+1:2]),
    .o_rd_data (w_rd_data)
  );

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed self-checking bench for apb_slave_mem (DEPTH=64, WAIT_STATES=2).
module tb_apb_slave_mem;
  import apb_pkg::*;

`ifdef APB_SLV_WAIT_EN
  localparam int EXP_LAT = 3;
`else
  localparam int EXP_LAT = 1;
`endif

  logic                  pclk = 1'b0;
  logic                  preset;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [APB_ADDR_W-1:0] paddr;
  logic [APB_DATA_W-1:0] pwdata;
  logic [APB_DATA_W-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  int total = 0;
  int bad   = 0;

  always #5 pclk = ~pclk;

  apb_slave_mem #(
    .DEPTH       (64),
    .WAIT_STATES (2)
  ) dut (
    .pclk    (pclk),
    .preset  (preset),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // SETUP then ACCESS; returns data/error sampled in the pready cycle and the
  // number of ACCESS cycles up to and including pready.
  task automatic xfer(input logic wr, input logic [32:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic err, output int lat);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    @(posedge pclk); #1;
    penable = 1'b1;
    pwdata  = ~wd;
    lat = 1;
    forever begin
      @(negedge pclk);
      if (pready === 1'b1) break;
      chk("pslverr_in_wait", {31'd0, pslverr}, 32'd0);
      lat++;
      if (lat > 20) begin
        total++; bad++;
        $error("FAIL timeout: observed=no_pready expected=pready");
        break;
      end
      @(posedge pclk); #1;
    end
    rd  = prdata;
    err = pslverr;
  endtask

  task automatic bus_idle();
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  logic [31:0] rd;
  logic        err;
  int          lat;

  initial begin
    preset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0;
    #12;
    chk("rst_pready",  {31'd0, pready},  32'd0);
    chk("rst_pslverr", {31'd0, pslverr}, 32'd0);
    chk("rst_prdata",  prdata,           32'd0);
    repeat (2) @(posedge pclk);
    #1 preset = 1'b1;

    // Known contents for later comparisons
    xfer(1'b1, 33'h0_0000_0000, 32'h1111_1111, rd, err, lat); bus_idle();
    xfer(1'b1, 33'h0_0000_0004, 32'h4444_4444, rd, err, lat); bus_idle();
    xfer(1'b1, 33'h0_0000_000C, 32'hCCCC_CCCC, rd, err, lat); bus_idle();

    xfer(1'b1, 33'h0_0000_0010, 32'hDEAD_BEEF, rd, err, lat);
    chk("wr10_err", {31'd0, err}, 32'd0);
    chk("wr10_lat", 32'(lat), 32'(EXP_LAT));
    bus_idle();
    xfer(1'b0, 33'h0_0000_0010, 32'h0, rd, err, lat);
    chk("rd10_data", rd, 32'hDEAD_BEEF);
    chk("rd10_err", {31'd0, err}, 32'd0);
    chk("rd10_lat", 32'(lat), 32'(EXP_LAT));
    bus_idle();

    // Out-of-range read, with the decode bit set to show it is ignored elsewhere
    xfer(1'b0, 33'h0_0000_0100, 32'h0, rd, err, lat);
    chk("oor_err", {31'd0, err}, 32'd1);
    chk("oor_data", rd, 32'h0);
    chk("oor_lat", 32'(lat), 32'(EXP_LAT));
    bus_idle();
    xfer(1'b0, 33'h1_0000_0000, 32'h0, rd, err, lat);
    chk("rd0_after_oor", rd, 32'h1111_1111);
    chk("rd0_after_oor_err", {31'd0, err}, 32'd0);
    bus_idle();

    // Misaligned write must not touch word 0
    xfer(1'b1, 33'h0_0000_0002, 32'h1234_5678, rd, err, lat);
    chk("mis_err", {31'd0, err}, 32'd1);
    bus_idle();
    xfer(1'b0, 33'h0_0000_0000, 32'h0, rd, err, lat);
    chk("rd0_after_mis", rd, 32'h1111_1111);
    bus_idle();

    // Back-to-back write then read of the same word
    xfer(1'b1, 33'h0_0000_0008, 32'hA5A5_A5A5, rd, err, lat);
    chk("b2b_wr_err", {31'd0, err}, 32'd0);
    xfer(1'b0, 33'h0_0000_0008, 32'h0, rd, err, lat);
    chk("b2b_rd_data", rd, 32'hA5A5_A5A5);
    chk("b2b_rd_err", {31'd0, err}, 32'd0);
    chk("b2b_rd_lat", 32'(lat), 32'(EXP_LAT));
    bus_idle();

    // Abort: psel dropped in the first ACCESS cycle
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 33'h4; pwdata = 32'hFFFF_FFFF;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk);
    @(negedge pclk);
    chk("abort_idle_pready", {31'd0, pready}, 32'd0);
    xfer(1'b0, 33'h0_0000_0004, 32'h0, rd, err, lat);
    chk("abort_rd4", rd, 32'h4444_4444);
    chk("abort_rd4_lat", 32'(lat), 32'(EXP_LAT));
    bus_idle();

    // Reset in the ACCESS phase of a write to 0xC
    xfer(1'b0, 33'h0_0000_0010, 32'h0, rd, err, lat);
    chk("pre_rst_prdata", rd, 32'hDEAD_BEEF);
    bus_idle();
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 33'hC; pwdata = 32'h0BAD_F00D;
    @(posedge pclk); #1;
    penable = 1'b1;
    #2 preset = 1'b0;
    #1;
    chk("midrst_pready",  {31'd0, pready},  32'd0);
    chk("midrst_pslverr", {31'd0, pslverr}, 32'd0);
    chk("midrst_prdata",  prdata,           32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    preset = 1'b1;
    xfer(1'b0, 33'h0_0000_000C, 32'h0, rd, err, lat);
    chk("midrst_rdC", rd, 32'hCCCC_CCCC);
    bus_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
